// File: rtl/wrr_vchanel_scheduler_pkg.sv
// Shared types and constants for the weighted round-robin virtual-channel scheduler.
// Holds channel encodings, default weights and the FSM state encoding.
package wrr_pkg;

  localparam int NUM_VCH = 4;
  localparam int PTR_W   = 2;

  localparam int WEIGHT0_DEF = 4;
  localparam int WEIGHT1_DEF = 2;
  localparam int WEIGHT2_DEF = 2;
  localparam int WEIGHT3_DEF = 1;

  typedef enum logic [PTR_W-1:0] {
    VCHANEL0 = 2'b00,
    VCHANEL1 = 2'b01,
    VCHANEL2 = 2'b10,
    VCHANEL3 = 2'b11
  } vch_e;

  // IDLE: no grant in the previous cycle; SERVE: a word was granted last cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/wrr_vchanel_scheduler_if.sv
// Bundle between the scheduler, the four VC FIFOs and the downstream stage.
// Handshake: empty_vchanelN=0 means channel N offers a word (inverted valid); full_down=0 means
// downstream accepts (ready). pop_vchanelN is a strobe: a word moves when pop=1 at posedge clk.
// arbiter/valid_out describe the word presented to the output mux in the following cycle.
interface wrr_vchanel_scheduler_if;
  import wrr_pkg::*;

  logic             enb;
  logic             empty_vchanel0;
  logic             empty_vchanel1;
  logic             empty_vchanel2;
  logic             empty_vchanel3;
  logic             full_down;
  logic             pop_vchanel0;
  logic             pop_vchanel1;
  logic             pop_vchanel2;
  logic             pop_vchanel3;
  logic [PTR_W-1:0] arbiter;
  logic             valid_out;

  modport master (
    output enb,
    output empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    output full_down,
    input  pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
    input  arbiter,
    input  valid_out
  );

  modport slave (
    input  enb,
    input  empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
    input  full_down,
    output pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
    output arbiter,
    output valid_out
  );

endinterface

// File: rtl/wrr_vchanel_scheduler_rr_next_sel.sv
// Rotating-priority finder: first set bit of req starting at ptr and wrapping upward.
// Purely combinational; shared with the credit-return arbiter.
module rr_next_sel
  import wrr_pkg::*;
(
  input  logic [NUM_VCH-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   idx,
  output logic               found
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester is the last one written.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = NUM_VCH - 1; i >= 0; i--) begin
      cand = ptr + PTR_W'(i);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_vchanel_scheduler.sv
// Weighted round-robin scheduler for the 4-VC output mux: Mealy pops, registered arbiter/valid_out.
// Optional build macro WRR_RUNTIME_WEIGHTS_EN replaces the WEIGHTn parameters with weight_vchanelN ports.
module wrr_vchanel_scheduler
  import wrr_pkg::*;
#(
  parameter int WEIGHT0 = WEIGHT0_DEF,
  parameter int WEIGHT1 = WEIGHT1_DEF,
  parameter int WEIGHT2 = WEIGHT2_DEF,
  parameter int WEIGHT3 = WEIGHT3_DEF,
  parameter int CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef WRR_RUNTIME_WEIGHTS_EN
  input  logic [CNT_W-1:0]       weight_vchanel0,
  input  logic [CNT_W-1:0]       weight_vchanel1,
  input  logic [CNT_W-1:0]       weight_vchanel2,
  input  logic [CNT_W-1:0]       weight_vchanel3,
`endif
  wrr_vchanel_scheduler_if.slave vc,
  output state_e                 dbg_state,
  output logic [PTR_W-1:0]       dbg_ptr,
  output logic [CNT_W-1:0]       dbg_credit
);

  function automatic logic [CNT_W-1:0] clamp_w(input logic [CNT_W-1:0] w);
    return (w == '0) ? CNT_W'(1) : w;
  endfunction

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic [PTR_W-1:0]   arb_q, arb_d;
  logic [CNT_W-1:0]   wt [NUM_VCH];
  logic [NUM_VCH-1:0] non_empty;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_found;
  logic               grant;
  logic [CNT_W-1:0]   credit_nx;
  logic [PTR_W-1:0]   next_turn;

  // Reload values; only read when a turn starts, so a change never touches a running turn.
  always_comb begin
`ifdef WRR_RUNTIME_WEIGHTS_EN
    wt[0] = clamp_w(weight_vchanel0);
    wt[1] = clamp_w(weight_vchanel1);
    wt[2] = clamp_w(weight_vchanel2);
    wt[3] = clamp_w(weight_vchanel3);
`else
    wt[0] = clamp_w(CNT_W'(WEIGHT0));
    wt[1] = clamp_w(CNT_W'(WEIGHT1));
    wt[2] = clamp_w(CNT_W'(WEIGHT2));
    wt[3] = clamp_w(CNT_W'(WEIGHT3));
`endif
  end

  assign non_empty = ~{vc.empty_vchanel3, vc.empty_vchanel2,
                       vc.empty_vchanel1, vc.empty_vchanel0};

  rr_next_sel u_next_sel (
    .req   (non_empty),
    .ptr   (ptr_q),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign grant     = vc.enb & ~rst & ~vc.full_down & sel_found;
  assign next_turn = ptr_inc(sel_idx);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: SERVE exactly when a word is popped this cycle.
  always_comb begin
    state_d = IDLE;
    if (grant) begin
      state_d = SERVE;
    end
  end

  // FSM outputs: pops are Mealy on the current decision, the rest come from flops.
  always_comb begin
    vc.pop_vchanel0 = grant && (sel_idx == VCHANEL0);
    vc.pop_vchanel1 = grant && (sel_idx == VCHANEL1);
    vc.pop_vchanel2 = grant && (sel_idx == VCHANEL2);
    vc.pop_vchanel3 = grant && (sel_idx == VCHANEL3);
    vc.valid_out    = (state_q == SERVE);
    vc.arbiter      = arb_q;
  end

  // Turn bookkeeping: a skip hands the turn to the granted channel and forfeits the old credit.
  always_comb begin
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    arb_d     = arb_q;
    credit_nx = credit_q;
    if (grant) begin
      arb_d = sel_idx;
      ptr_d = sel_idx;
      if (sel_idx == ptr_q) begin
        credit_nx = credit_q - CNT_W'(1);
      end else begin
        credit_nx = wt[sel_idx] - CNT_W'(1);
      end
      if (credit_nx == '0) begin
        ptr_d    = next_turn;
        credit_d = wt[next_turn];
      end else begin
        credit_d = credit_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= VCHANEL0;
      credit_q <= wt[0];
      arb_q    <= VCHANEL0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      arb_q    <= arb_d;
    end
  end

  assign dbg_state  = state_q;
  assign dbg_ptr    = ptr_q;
  assign dbg_credit = credit_q;

endmodule

// File: tb/tb_wrr_vchanel_scheduler.sv
// Directed bench for wrr_vchanel_scheduler: turn-level reference model checked every cycle,
// plus literal arbiter sequences and hand-computed pointer/credit values.
module tb_wrr_vchanel_scheduler;
  import wrr_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wrr_vchanel_scheduler_if vc_if();

  state_e           dbg_state;
  logic [1:0]       dbg_ptr;
  logic [CNT_W-1:0] dbg_credit;

`ifdef WRR_RUNTIME_WEIGHTS_EN
  logic [CNT_W-1:0] w_rt [4];
`endif

  int tests_run  = 0;
  int tests_fail = 0;

  logic [1:0] exp_q[$];
  bit         cap_en = 1'b0;

  // Reference model: who holds the turn and how many grants remain in it.
  bit         m_known = 1'b0;
  int         m_ptr;
  int         m_left;
  int         m_arb;
  int         m_vout;

  wrr_vchanel_scheduler dut (
    .clk        (clk),
    .rst        (rst),
`ifdef WRR_RUNTIME_WEIGHTS_EN
    .weight_vchanel0 (w_rt[0]),
    .weight_vchanel1 (w_rt[1]),
    .weight_vchanel2 (w_rt[2]),
    .weight_vchanel3 (w_rt[3]),
`endif
    .vc         (vc_if),
    .dbg_state  (dbg_state),
    .dbg_ptr    (dbg_ptr),
    .dbg_credit (dbg_credit)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wt(input int c);
    int v;
`ifdef WRR_RUNTIME_WEIGHTS_EN
    v = int'(w_rt[c]);
`else
    case (c)
      0:       v = 4;
      1:       v = 2;
      2:       v = 2;
      default: v = 1;
    endcase
`endif
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [3:0] cur_empty();
    return {vc_if.empty_vchanel3, vc_if.empty_vchanel2,
            vc_if.empty_vchanel1, vc_if.empty_vchanel0};
  endfunction

  // Channel that wins this cycle, or -1 when nothing can be granted.
  function automatic int model_pick();
    logic [3:0] e;
    int c;
    e = cur_empty();
    if (rst || !vc_if.enb || vc_if.full_down) return -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (!e[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    if (rst) begin
      m_known = 1'b1;
      m_ptr   = 0;
      m_left  = wt(0);
      m_arb   = 0;
      m_vout  = 0;
    end else if (m_known) begin
      g = model_pick();
      if (g < 0) begin
        m_vout = 0;
      end else begin
        if (g == m_ptr) begin
          m_left = m_left - 1;
        end else begin
          m_ptr  = g;
          m_left = wt(g) - 1;
        end
        if (m_left == 0) begin
          m_ptr  = (g + 1) % 4;
          m_left = wt(m_ptr);
        end
        m_arb  = g;
        m_vout = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic en, input logic [3:0] e,
                       input logic f, input int n);
    rst                  = r;
    vc_if.enb            = en;
    vc_if.empty_vchanel0 = e[0];
    vc_if.empty_vchanel1 = e[1];
    vc_if.empty_vchanel2 = e[2];
    vc_if.empty_vchanel3 = e[3];
    vc_if.full_down      = f;
    repeat (n) @(negedge clk);
  endtask

  task automatic seq_done(input string name);
    cap_en = 1'b0;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- compare process / scoreboard ----------------
  initial begin
    int g;
    logic [3:0] exp_pop;
    forever begin
      @(negedge clk);
      #2;
      if (m_known || rst) begin
        g = m_known ? model_pick() : -1;
        exp_pop = (g < 0) ? 4'b0000 : (4'b0001 << g);
        chk("pops", int'({vc_if.pop_vchanel3, vc_if.pop_vchanel2,
                          vc_if.pop_vchanel1, vc_if.pop_vchanel0}), int'(exp_pop));
      end
      @(posedge clk);
      #1;
      model_step();
      if (m_known) begin
        chk("arbiter", int'(vc_if.arbiter), m_arb);
        chk("valid_out", int'(vc_if.valid_out), m_vout);
        chk("state", int'(dbg_state), m_vout);
        chk("ptr", int'(dbg_ptr), m_ptr);
        chk("credit", int'(dbg_credit), m_left);
      end
      if (cap_en && vc_if.valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("seq extra grant", int'(vc_if.arbiter), -1);
        end else begin
          chk("seq arbiter", int'(vc_if.arbiter), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
`ifdef WRR_RUNTIME_WEIGHTS_EN
    w_rt[0] = 4'd4; w_rt[1] = 4'd2; w_rt[2] = 4'd2; w_rt[3] = 4'd1;
`endif
    vc_if.enb            = 1'b1;
    vc_if.empty_vchanel0 = 1'b1;
    vc_if.empty_vchanel1 = 1'b1;
    vc_if.empty_vchanel2 = 1'b1;
    vc_if.empty_vchanel3 = 1'b1;
    vc_if.full_down      = 1'b0;
    rst                  = 1'b1;
    @(negedge clk);

    // Reset state
    drive(1, 1, 4'b0000, 0, 1);
    chk("reset valid_out", int'(vc_if.valid_out), 0);
    chk("reset arbiter", int'(vc_if.arbiter), 0);
    chk("reset ptr", int'(dbg_ptr), 0);
    chk("reset credit", int'(dbg_credit), 4);

    // All channels busy: 4/2/2/1 rotation
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    cap_en = 1'b1;
    drive(0, 1, 4'b0000, 0, 10);
    seq_done("seq all busy");

    // vchanel1 permanently empty: zero-cycle skip
    drive(1, 1, 4'b0000, 0, 1);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0};
    cap_en = 1'b1;
    drive(0, 1, 4'b0010, 0, 8);
    seq_done("seq skip vch1");

    // full_down after the second vchanel0 grant keeps the remaining credit
    drive(1, 1, 4'b0000, 0, 1);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    cap_en = 1'b1;
    drive(0, 1, 4'b0000, 0, 2);
    drive(0, 1, 4'b0000, 1, 3);
    chk("full hold arbiter", int'(vc_if.arbiter), 0);
    chk("full valid_out", int'(vc_if.valid_out), 0);
    chk("full credit kept", int'(dbg_credit), 2);
    drive(0, 1, 4'b0000, 0, 3);
    seq_done("seq full_down");

    // All empty, then only vchanel3
    drive(1, 1, 4'b0000, 0, 1);
    exp_q.delete();
    cap_en = 1'b1;
    drive(0, 1, 4'b1111, 0, 5);
    seq_done("seq all empty");
    exp_q = '{2'd3, 2'd3, 2'd3};
    cap_en = 1'b1;
    drive(0, 1, 4'b0111, 0, 3);
    seq_done("seq only vch3");
    chk("vch3 turn passed ptr", int'(dbg_ptr), 0);

    // Channel emptying mid-turn forfeits its remaining credit
    drive(1, 1, 4'b0000, 0, 1);
    exp_q = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    cap_en = 1'b1;
    drive(0, 1, 4'b0000, 0, 2);
    drive(0, 1, 4'b0001, 0, 2);
    drive(0, 1, 4'b0000, 0, 1);
    seq_done("seq forfeit");

    // Reset mid-turn with ptr=2, credit=1; then enb=0 freezes
    drive(1, 1, 4'b0000, 0, 1);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    cap_en = 1'b1;
    drive(0, 1, 4'b0000, 0, 7);
    seq_done("seq pre-reset");
    chk("pre-reset ptr", int'(dbg_ptr), 2);
    chk("pre-reset credit", int'(dbg_credit), 1);
    drive(1, 1, 4'b0000, 0, 1);
    chk("mid reset arbiter", int'(vc_if.arbiter), 0);
    chk("mid reset valid_out", int'(vc_if.valid_out), 0);
    chk("mid reset ptr", int'(dbg_ptr), 0);
    chk("mid reset credit", int'(dbg_credit), 4);
    drive(0, 0, 4'b0000, 0, 3);
    chk("enb0 ptr", int'(dbg_ptr), 0);
    chk("enb0 credit", int'(dbg_credit), 4);
    chk("enb0 valid_out", int'(vc_if.valid_out), 0);
    exp_q = '{2'd0, 2'd0};
    cap_en = 1'b1;
    drive(0, 1, 4'b0000, 0, 2);
    seq_done("seq after enb");

`ifdef WRR_RUNTIME_WEIGHTS_EN
    // Runtime weights: strict rotation, then weight0=3 picked up at the next vchanel0 turn
    w_rt[0] = 4'd1; w_rt[1] = 4'd1; w_rt[2] = 4'd1; w_rt[3] = 4'd1;
    drive(1, 1, 4'b0000, 0, 1);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    cap_en = 1'b1;
    drive(0, 1, 4'b0000, 0, 6);
    seq_done("seq rt rotation");
    drive(1, 1, 4'b0000, 0, 1);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    cap_en = 1'b1;
    drive(0, 1, 4'b0000, 0, 2);
    w_rt[0] = 4'd3;
    drive(0, 1, 4'b0000, 0, 6);
    seq_done("seq rt weight change");
`endif

    drive(0, 1, 4'b1111, 0, 2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
